// File: rtl/sdram_arb.sv
// Three-client arbiter in front of the SDRAM controller.
// Level-held client requests become edge-style rd/we strobes. At most one controller
// transaction is in flight. Read data and a one-cycle ack go back to the granted client.
module sdram_arb #(
    parameter int unsigned AW          = 26,
    parameter int unsigned ACK_TIMEOUT = 8,
    parameter int unsigned STARVE_MAX  = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    // port 0: loader writes
    input  logic          p0_req,
    input  logic [AW-1:0] p0_addr,
    input  logic [15:0]   p0_data,
    input  logic [1:0]    p0_wtbt,
    output logic          p0_ack,
    // port 1: cpu single-word reads
    input  logic          p1_req,
    input  logic [AW-1:0] p1_addr,
    output logic [15:0]   p1_data,
    output logic          p1_ack,
    // port 2: sprite four-word burst reads
    input  logic          p2_req,
    input  logic [AW-1:0] p2_addr,
    output logic [63:0]   p2_data,
    output logic          p2_ack,
    // controller side
    output logic          mem_sel,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_din,
    output logic [1:0]    mem_wtbt,
    output logic          mem_we,
    output logic          mem_rd,
    output logic          mem_rd_type,
    input  logic [63:0]   mem_dout,
    input  logic          mem_ready
);

    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitLo,
        StWaitHi,
        StDone,
        StGap
    } state_e;

    typedef enum logic [1:0] {
        GntP0,
        GntP1,
        GntP2
    } gnt_e;

    state_e          state_q, state_d;
    gnt_e            gnt_q, gnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [15:0]     din_q, din_d;
    logic [1:0]      wtbt_q, wtbt_d;
    logic            rd_type_q, rd_type_d;
    logic [15:0]     p1_data_q, p1_data_d;
    logic [63:0]     p2_data_q, p2_data_d;
    logic            p2_granted;
    logic            p2_first;
    logic            capture;
    logic            busy;

    // Once port 2 has waited long enough it outranks port 1 (never port 0)
    assign p2_first = (starve_q >= SW'(STARVE_MAX));

    // Next-state: grant selection, handshake sequencing and read-data capture
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        to_cnt_d   = to_cnt_q;
        addr_d     = addr_q;
        din_d      = din_q;
        wtbt_d     = wtbt_q;
        rd_type_d  = rd_type_q;
        p1_data_d  = p1_data_q;
        p2_data_d  = p2_data_q;
        p2_granted = 1'b0;
        capture    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mem_ready && (p0_req || p1_req || p2_req)) begin
                    state_d = StIssue;
                    if (p0_req) begin
                        gnt_d     = GntP0;
                        addr_d    = p0_addr;
                        din_d     = p0_data;
                        wtbt_d    = p0_wtbt;
                        rd_type_d = 1'b0;
                    end else if (p2_req && (p2_first || !p1_req)) begin
                        gnt_d      = GntP2;
                        addr_d     = p2_addr;
                        din_d      = '0;
                        wtbt_d     = '0;
                        rd_type_d  = 1'b1;
                        p2_granted = 1'b1;
                    end else begin
                        gnt_d     = GntP1;
                        addr_d    = p1_addr;
                        din_d     = '0;
                        wtbt_d    = '0;
                        rd_type_d = 1'b0;
                    end
                end
            end
            StIssue: begin
                to_cnt_d = '0;
                state_d  = StWaitLo;
            end
            StWaitLo: begin
                // A controller that never drops ready is treated as done after the timeout
                if (!mem_ready) begin
                    state_d = StWaitHi;
                end else if (to_cnt_q == TW'(ACK_TIMEOUT - 1)) begin
                    state_d = StDone;
                    capture = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            StWaitHi: begin
                if (mem_ready) begin
                    state_d = StDone;
                    capture = 1'b1;
                end
            end
            StDone:  state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Load read data on entry to DONE so it is valid alongside the ack
        if (capture) begin
            if (gnt_q == GntP1) p1_data_d = mem_dout[15:0];
            if (gnt_q == GntP2) p2_data_d = mem_dout;
        end
    end

    // Starvation counter for port 2: saturating, cleared on grant or when idle
    always_comb begin
        starve_d = starve_q;
        if (!p2_req || p2_granted) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            gnt_q     <= GntP0;
            to_cnt_q  <= '0;
            starve_q  <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            wtbt_q    <= '0;
            rd_type_q <= 1'b0;
            p1_data_q <= '0;
            p2_data_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            to_cnt_q  <= to_cnt_d;
            starve_q  <= starve_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            wtbt_q    <= wtbt_d;
            rd_type_q <= rd_type_d;
            p1_data_q <= p1_data_d;
            p2_data_q <= p2_data_d;
        end
    end

    // Strobes are held from ISSUE through WAIT_HI; acks pulse in DONE
    always_comb begin
        busy    = (state_q == StIssue) || (state_q == StWaitLo) || (state_q == StWaitHi);
        mem_sel = busy;
        mem_we  = busy && (gnt_q == GntP0);
        mem_rd  = busy && (gnt_q != GntP0);
        p0_ack  = (state_q == StDone) && (gnt_q == GntP0);
        p1_ack  = (state_q == StDone) && (gnt_q == GntP1);
        p2_ack  = (state_q == StDone) && (gnt_q == GntP2);
    end

    assign mem_addr    = addr_q;
    assign mem_din     = din_q;
    assign mem_wtbt    = wtbt_q;
    assign mem_rd_type = rd_type_q;
    assign p1_data     = p1_data_q;
    assign p2_data     = p2_data_q;

endmodule

// File: tb/tb_sdram_arb.sv
// Directed self-checking bench for sdram_arb; the controller is played inline by the stimulus.
module tb_sdram_arb;

    localparam int unsigned AW = 26;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          p0_req = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [15:0]   p0_data = '0;
    logic [1:0]    p0_wtbt = '0;
    logic          p0_ack;
    logic          p1_req = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [15:0]   p1_data;
    logic          p1_ack;
    logic          p2_req = 1'b0;
    logic [AW-1:0] p2_addr = '0;
    logic [63:0]   p2_data;
    logic          p2_ack;
    logic          mem_sel;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic [1:0]    mem_wtbt;
    logic          mem_we;
    logic          mem_rd;
    logic          mem_rd_type;
    logic [63:0]   mem_dout = '0;
    logic          mem_ready = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    sdram_arb #(.AW(AW), .ACK_TIMEOUT(8), .STARVE_MAX(64)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .p0_req      (p0_req),
        .p0_addr     (p0_addr),
        .p0_data     (p0_data),
        .p0_wtbt     (p0_wtbt),
        .p0_ack      (p0_ack),
        .p1_req      (p1_req),
        .p1_addr     (p1_addr),
        .p1_data     (p1_data),
        .p1_ack      (p1_ack),
        .p2_req      (p2_req),
        .p2_addr     (p2_addr),
        .p2_data     (p2_data),
        .p2_ack      (p2_ack),
        .mem_sel     (mem_sel),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_wtbt    (mem_wtbt),
        .mem_we      (mem_we),
        .mem_rd      (mem_rd),
        .mem_rd_type (mem_rd_type),
        .mem_dout    (mem_dout),
        .mem_ready   (mem_ready)
    );

    always #5 clk = ~clk;

    // Absolute time limit in case the design stalls somewhere unexpected
    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, required finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance until a strobe is issued (bounded); returns the cycles spent
    task automatic wait_issue(input string tag, output int cycles);
        cycles = 0;
        while (!mem_sel && cycles < 40) begin
            tick;
            cycles++;
        end
        check(tag, {63'd0, mem_sel}, 64'd1);
    endtask

    // Called in ISSUE: ready falls, then rises with data; returns in DONE
    task automatic serve(input logic [63:0] dout);
        mem_ready = 1'b0;
        tick;
        tick;
        mem_dout  = dout;
        mem_ready = 1'b1;
        tick;
    endtask

    function automatic int exp_port(input int k);
        if (k <= 10) return 1;
        if (k == 11) return 2;
        if (k <= 21) return 1;
        if (k == 22) return 0;
        if (k == 23) return 2;
        return 1;
    endfunction

    initial begin
        int cyc;
        int who;
        logic [2:0] acks;

        // Reset state
        #3;
        check("rst_sel", {63'd0, mem_sel}, 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_acks", {61'd0, p2_ack, p1_ack, p0_ack}, 64'd0);
        check("rst_p2_data", p2_data, 64'd0);
        #9 reset_n = 1'b1;
        tick;

        // 1: single read
        p1_req  = 1'b1;
        p1_addr = 26'h000100;
        tick;
        check("t1_rd", {62'd0, mem_rd, mem_we}, 64'b10);
        check("t1_type", {63'd0, mem_rd_type}, 64'd0);
        check("t1_addr", 64'(mem_addr), 64'h100);
        mem_ready = 1'b0;
        tick;
        check("t1_rd_held", {63'd0, mem_rd}, 64'd1);
        tick;
        check("t1_no_early_ack", {63'd0, p1_ack}, 64'd0);
        mem_dout  = 64'h0000_0000_0000_BEEF;
        mem_ready = 1'b1;
        tick;
        check("t1_ack", {63'd0, p1_ack}, 64'd1);
        check("t1_data", 64'(p1_data), 64'hBEEF);
        check("t1_rd_low", {63'd0, mem_rd}, 64'd0);
        p1_req   = 1'b0;
        mem_dout = '0;
        tick;
        check("t1_ack_pulse", {63'd0, p1_ack}, 64'd0);
        check("t1_data_held", 64'(p1_data), 64'hBEEF);
        tick;

        // 2: write and read raised together, write wins
        p0_req  = 1'b1;
        p0_addr = 26'h2;
        p0_data = 16'h1234;
        p0_wtbt = 2'b11;
        p1_req  = 1'b1;
        p1_addr = 26'h200;
        tick;
        check("t2_we", {62'd0, mem_we, mem_rd}, 64'b10);
        check("t2_addr", 64'(mem_addr), 64'h2);
        check("t2_din", 64'(mem_din), 64'h1234);
        check("t2_wtbt", 64'(mem_wtbt), 64'd3);
        serve(64'd0);
        check("t2_ack0", {61'd0, p2_ack, p1_ack, p0_ack}, 64'b001);
        p0_req = 1'b0;
        wait_issue("t2_issue1", cyc);
        check("t2_gap_cycles", 64'(cyc), 64'd3);
        check("t2_rd1", {62'd0, mem_we, mem_rd}, 64'b01);
        check("t2_addr1", 64'(mem_addr), 64'h200);
        serve(64'h5555);
        check("t2_ack1", {61'd0, p2_ack, p1_ack, p0_ack}, 64'b010);
        check("t2_data1", 64'(p1_data), 64'h5555);
        p1_req = 1'b0;
        tick;
        tick;

        // 3: burst read
        p2_req  = 1'b1;
        p2_addr = 26'h40;
        tick;
        check("t3_type", {62'd0, mem_rd_type, mem_rd}, 64'b11);
        check("t3_addr", 64'(mem_addr), 64'h40);
        serve(64'h4444_3333_2222_1111);
        check("t3_ack", {61'd0, p2_ack, p1_ack, p0_ack}, 64'b100);
        check("t3_data", p2_data, 64'h4444_3333_2222_1111);
        p2_req   = 1'b0;
        mem_dout = '0;
        tick;
        check("t3_ack_pulse", {63'd0, p2_ack}, 64'd0);
        check("t3_data_held", p2_data, 64'h4444_3333_2222_1111);
        tick;

        // 4: starvation with p1/p2 held; p0 joins just before the second p2 win
        p1_req  = 1'b1;
        p1_addr = 26'h300;
        p2_req  = 1'b1;
        p2_addr = 26'h80;
        for (int k = 0; k < 25; k++) begin
            wait_issue($sformatf("t4_issue%0d", k), cyc);
            who = mem_we ? 0 : (mem_rd_type ? 2 : 1);
            check($sformatf("t4_grant%0d", k), 64'(who), 64'(exp_port(k)));
            if (k == 21) begin
                p0_req  = 1'b1;
                p0_addr = 26'h8;
                p0_data = 16'h00A5;
                p0_wtbt = 2'b01;
            end
            serve(64'(k + 1));
            acks = {p2_ack, p1_ack, p0_ack};
            check($sformatf("t4_ack%0d", k), 64'(acks), 64'(3'b001 << exp_port(k)));
            if (k == 22) p0_req = 1'b0;
        end
        check("t4_p1_last", 64'(p1_data), 64'd25);
        check("t4_p2_last", p2_data, 64'd24);
        p1_req = 1'b0;
        p2_req = 1'b0;
        tick;
        tick;

        // 5: controller disabled, ready stuck high
        p1_req   = 1'b1;
        p1_addr  = 26'h500;
        mem_dout = '0;
        tick;
        check("t5_rd", {63'd0, mem_rd}, 64'd1);
        cyc = 0;
        while (!p1_ack && cyc < 20) begin
            tick;
            cyc++;
        end
        check("t5_timeout_cycles", 64'(cyc), 64'd9);
        check("t5_data", 64'(p1_data), 64'd0);
        p1_req = 1'b0;
        tick;
        check("t5_gap_idle", {62'd0, mem_sel, p1_ack}, 64'd0);
        tick;

        // 6: reset during WAIT_HI
        p2_req  = 1'b1;
        p2_addr = 26'h600;
        tick;
        mem_ready = 1'b0;
        tick;
        tick;
        check("t6_rd_whi", {63'd0, mem_rd}, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_strobes", {61'd0, mem_sel, mem_rd, mem_we}, 64'd0);
        check("t6_async_addr", 64'(mem_addr), 64'd0);
        check("t6_async_type", {63'd0, mem_rd_type}, 64'd0);
        check("t6_async_p1_data", 64'(p1_data), 64'd0);
        p2_req    = 1'b0;
        mem_dout  = 64'hDEAD;
        mem_ready = 1'b1;
        tick;
        tick;
        check("t6_no_ack", {61'd0, p2_ack, p1_ack, p0_ack}, 64'd0);
        check("t6_p2_data", p2_data, 64'd0);
        #3 reset_n = 1'b1;
        tick;
        p1_req  = 1'b1;
        p1_addr = 26'h700;
        wait_issue("t6_issue", cyc);
        check("t6_addr", 64'(mem_addr), 64'h700);
        serve(64'hCAFE);
        check("t6_ack", {61'd0, p2_ack, p1_ack, p0_ack}, 64'b010);
        check("t6_data", 64'(p1_data), 64'hCAFE);
        p1_req = 1'b0;
        tick;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_arb.md
Name: sdram_arb

Overview:
Three-client request arbiter sitting directly upstream of the SDRAM controller. It converts level-held client requests into the controller's edge-triggered rd/we strobes and its ready handshake. It serialises loader writes, CPU single-word reads and sprite four-word burst reads, and returns read data and a one-cycle ack to the granted client. Only one controller transaction is outstanding at any time.

Parameters:
AW, 26, byte address width, matching controller addr
ACK_TIMEOUT, 8, cycles to wait for mem_ready to fall before treating the access as complete
STARVE_MAX, 64, cycles port 2 may wait before it outranks port 1

Ports:
clk  in  1  system clock, same domain as SDRAM controller
reset_n  in  1  asynchronous active-low reset
p0_req  in  1  write request, level, held until p0_ack
p0_addr  in  AW  write byte address
p0_data  in  16  write data
p0_wtbt  in  2  byte-enable code, passed to controller wtbt
p0_ack  out  1  one-cycle pulse, write accepted by controller
p1_req  in  1  single-word read request, level
p1_addr  in  AW  read address, bit0 = 0
p1_data  out  16  read word, valid with p1_ack and held until next p1_ack
p1_ack  out  1  one-cycle pulse
p2_req  in  1  4-word burst read request, level
p2_addr  in  AW  burst start address, bits[2:0] = 0
p2_data  out  64  burst data (word0 in [15:0]), valid with p2_ack and held
p2_ack  out  1  one-cycle pulse
mem_sel  out  1  controller sel
mem_addr  out  AW  controller addr
mem_din  out  16  controller din
mem_wtbt  out  2  controller wtbt
mem_we  out  1  controller we strobe
mem_rd  out  1  controller rd strobe
mem_rd_type  out  1  0 = single, 1 = burst
mem_dout  in  64  controller dout
mem_ready  in  1  controller ready

Behaviour:
- Reset (async, while reset_n = 0): state IDLE. All outputs 0: mem_* = 0, p*_ack = 0, p1_data = 0, p2_data = 0. Starvation counter = 0. Reset mid-transaction abandons it with no ack.
- FSM states:
  - IDLE: if mem_ready = 1 and any request is pending, grant one. Latch addr/data/wtbt and rd_type into mem_* and go to ISSUE. Otherwise stay.
  - ISSUE: assert mem_sel = 1 plus mem_we (port 0) or mem_rd (ports 1/2) for this cycle. Go to WAIT_LO.
  - WAIT_LO: keep the strobe high. When mem_ready = 0, go to WAIT_HI. If ACK_TIMEOUT cycles elapse with no fall (controller disabled), go to DONE.
  - WAIT_HI: keep the strobe high. When mem_ready = 1, go to DONE.
  - DONE: drop mem_we/mem_rd/mem_sel. Pulse the granted port's ack. Port 1 loads p1_data = mem_dout[15:0]; port 2 loads p2_data = mem_dout. Go to GAP.
  - GAP: one cycle with strobes low, which guarantees a rising edge for the next request. Go to IDLE.
- Priority at grant: p0 > p1 > p2. Exception: if starve_cnt >= STARVE_MAX, p2 outranks p1 (but never p0).
- starve_cnt: increments (saturating) each cycle p2_req = 1 and p2 is not granted. Clears when p2 is granted or when p2_req = 0.
- A request is sampled only in IDLE. A request dropped before grant is ignored. A request dropped after grant still completes, and the ack is still pulsed.
- Client rules:
  - A client may re-raise req the cycle after its ack. It is then re-granted no earlier than 2 cycles after the ack (GAP, IDLE).
  - Requests held continuously across an ack are treated as a new request.
- Minimum turnaround: ISSUE → ack is ≥ 4 cycles (ISSUE, WAIT_LO ≥ 1, WAIT_HI ≥ 1, DONE).
- mem_addr/mem_din/mem_wtbt/mem_rd_type stay stable from ISSUE through DONE.
- Timeout path acks with whatever mem_dout shows (0 when the controller is disabled). No error flag.

Test Plan:
1. p1_req, addr 0x000100, controller returns dout[15:0] = 0xBEEF → mem_rd rises once with rd_type 0; p1_ack pulses 1 cycle after ready rises; p1_data = 0xBEEF held.
2. p0_req (addr 0x2, data 0x1234, wtbt 2'b11) and p1_req raised in the same cycle → p0 granted first with mem_we; p1 issued after the GAP; two acks, in order.
3. p2_req burst, addr 0x40, dout = 0x4444_3333_2222_1111 → mem_rd_type = 1; p2_data equals that value; p2_ack is one cycle.
4. p1_req held continuously with p2_req also high for > 64 cycles → p2 is granted once starve_cnt reaches 64, then p1 resumes; p0 still preempts p2 when also pending.
5. mem_ready stuck at 1 → after issue, 8 cycles in WAIT_LO, then ack with data 0; FSM returns to IDLE.
6. reset_n pulsed low during WAIT_HI → all outputs 0 immediately (asynchronously); no ack; the next request is served normally after release.
